// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight.
// Latency: accept edge N, result captured edge N+1, resp_valid from N+1; 3 cycles/op minimum.
// Backpressure: ready only in IDLE; RESP holds result until the granted port's resp_ready.
// Optional ALU_ARB_FIXED_PRIO_EN: port 0 always wins ties (default build is round-robin).
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_0,
  input  logic               req_valid_1,
  output logic               req_ready_0,
  output logic               req_ready_1,
  input  logic [CTRL_W-1:0]  req_ctrl_0,
  input  logic [CTRL_W-1:0]  req_ctrl_1,
  input  logic [DATA_W-1:0]  req_in1_0,
  input  logic [DATA_W-1:0]  req_in1_1,
  input  logic [DATA_W-1:0]  req_in2_0,
  input  logic [DATA_W-1:0]  req_in2_1,
  input  logic [SHAMT_W-1:0] req_shamt_0,
  input  logic [SHAMT_W-1:0] req_shamt_1,
  output logic               resp_valid_0,
  output logic               resp_valid_1,
  input  logic               resp_ready_0,
  input  logic               resp_ready_1,
  output logic [DATA_W-1:0]  resp_out,
  output logic               resp_zero,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q;
  logic               grant_id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic               last_grant_q;
`endif
  logic [CTRL_W-1:0]  ctrl_q;
  logic [DATA_W-1:0]  in1_q;
  logic [DATA_W-1:0]  in2_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [DATA_W-1:0]  resp_out_q;
  logic               resp_zero_q;
  logic [1:0]         resp_vld_q;

  logic               gnt_sel;
  logic               accept;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [DATA_W-1:0]  in1_d;
  logic [DATA_W-1:0]  in2_d;
  logic [SHAMT_W-1:0] shamt_d;
  logic               resp_rdy_g;

  // Pick the winning port: lone requester wins, ties go to the port not served last.
  always_comb begin
    gnt_sel = 1'b0;
    if (req_valid_0 && req_valid_1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_sel = 1'b0;
`else
      gnt_sel = ~last_grant_q;
`endif
    end else begin
      gnt_sel = req_valid_1;
    end
  end

  // A grant is only offered while idle; ready goes to the winner alone.
  assign accept      = (state_q == IDLE) && (req_valid_0 || req_valid_1);
  assign req_ready_0 = accept && !gnt_sel;
  assign req_ready_1 = accept &&  gnt_sel;

  assign ctrl_d  = gnt_sel ? req_ctrl_1  : req_ctrl_0;
  assign in1_d   = gnt_sel ? req_in1_1   : req_in1_0;
  assign in2_d   = gnt_sel ? req_in2_1   : req_in2_0;
  assign shamt_d = gnt_sel ? req_shamt_1 : req_shamt_0;

  // Only the granted port's resp_ready can retire the response.
  assign resp_rdy_g = grant_id_q ? resp_ready_1 : resp_ready_0;

  // Control FSM plus operand and response registers; a reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
      ctrl_q       <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      shamt_q      <= '0;
      resp_out_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_vld_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ctrl_q       <= ctrl_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            shamt_q      <= shamt_d;
            grant_id_q   <= gnt_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= gnt_sel;
`endif
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          resp_out_q  <= alu_out;
          resp_zero_q <= alu_zero;
          resp_vld_q  <= grant_id_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (resp_rdy_g) begin
            resp_vld_q <= 2'b00;
            state_q    <= IDLE;
          end
        end
        default: begin
          resp_vld_q <= 2'b00;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_shamt    = shamt_q;
  assign alu_ctrl     = ctrl_q;
  assign resp_out     = resp_out_q;
  assign resp_zero    = resp_zero_q;
  assign resp_valid_0 = resp_vld_q[0];
  assign resp_valid_1 = resp_vld_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic [31:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_out;
  logic        resp_zero;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
    .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_out(resp_out), .resp_zero(resp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Behavioural ALU: shifts act on in2, SLT is signed, unknown opcodes yield 0.
  always_comb begin
    alu_out = 32'h0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0011: alu_out = alu_in2 << alu_shamt;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = {31'h0, $signed(alu_in1) < $signed(alu_in2)};
      4'b1100: alu_out = ~(alu_in1 | alu_in2);
      default: alu_out = 32'h0;
    endcase
  end
  assign alu_zero = (alu_out == 32'h0);

  typedef struct {
    int          port;
    logic [3:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    if (p == 0) begin
      req_ctrl_0 = c; req_in1_0 = a; req_in2_0 = b; req_shamt_0 = s; req_valid_0 = 1'b1;
    end else begin
      req_ctrl_1 = c; req_in1_1 = a; req_in2_1 = b; req_shamt_1 = s; req_valid_1 = 1'b1;
    end
  endtask

  // One full operation from the IDLE cycle: grant, EXEC, RESP (resp_ready high), back to IDLE.
  task automatic serve(input string nm, input int p, input logic [3:0] ectrl,
                       input logic [31:0] ein1, input logic [31:0] eout,
                       input logic ezero, input bit drop);
    logic [1:0] onehot;
    onehot = (p == 1) ? 2'b10 : 2'b01;
    #1;
    chk({nm, " req_ready"}, {30'h0, req_ready_1, req_ready_0}, {30'h0, onehot});
    tick();
    if (drop) begin
      if (p == 0) req_valid_0 = 1'b0;
      else        req_valid_1 = 1'b0;
    end
    chk({nm, " exec alu_ctrl"}, {28'h0, alu_ctrl}, {28'h0, ectrl});
    chk({nm, " exec alu_in1"}, alu_in1, ein1);
    chk({nm, " exec resp_valid"}, {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    chk({nm, " exec ready"}, {30'h0, req_ready_1, req_ready_0}, 32'h0);
    tick();
    chk({nm, " resp_valid"}, {30'h0, resp_valid_1, resp_valid_0}, {30'h0, onehot});
    chk({nm, " resp_out"}, resp_out, eout);
    chk({nm, " resp_zero"}, {31'h0, resp_zero}, {31'h0, ezero});
    tick();
    chk({nm, " resp_valid drop"}, {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    chk({nm, " alu_ctrl held"}, {28'h0, alu_ctrl}, {28'h0, ectrl});
  endtask

  initial begin
    int order[3];
    int left0, left1;
    logic [31:0] held;

    vecs[0] = '{0, 4'b0010, 32'd5,         32'd7,         5'd0,  32'd12,        1'b0};
    vecs[1] = '{1, 4'b0111, 32'd3,         32'd8,         5'd0,  32'd1,         1'b0};
    vecs[2] = '{0, 4'b1111, 32'd5,         32'd7,         5'd0,  32'd0,         1'b1};
    vecs[3] = '{1, 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0,  32'h0000_00F0, 1'b0};
    vecs[4] = '{0, 4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0};
    vecs[5] = '{1, 4'b1100, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{0, 4'b0110, 32'd3,         32'd5,         5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[7] = '{1, 4'b0011, 32'h0,         32'd3,         5'd31, 32'h8000_0000, 1'b0};
    vecs[8] = '{0, 4'b0111, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0};

    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_ctrl_0 = '0; req_ctrl_1 = '0; req_in1_0 = '0; req_in1_1 = '0;
    req_in2_0 = '0; req_in2_1 = '0; req_shamt_0 = '0; req_shamt_1 = '0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    tick();
    tick();
    chk("reset resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    chk("reset resp_out", resp_out, 32'h0);
    chk("reset resp_zero", {31'h0, resp_zero}, 32'h0);
    chk("reset alu_in1", alu_in1, 32'h0);
    chk("reset alu_in2", alu_in2, 32'h0);
    chk("reset alu_ctrl_shamt", {23'h0, alu_shamt, alu_ctrl}, 32'h0);
    chk("reset req_ready", {30'h0, req_ready_1, req_ready_0}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Simultaneous requests right after reset; port 0 keeps re-requesting once.
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 1};
`else
    order = '{0, 1, 0};
`endif
    left0 = 2; left1 = 1;
    drive(0, 4'b0110, 32'd9, 32'd9, 5'd0);
    drive(1, 4'b0011, 32'd0, 32'd1, 5'd4);
    for (int k = 0; k < 3; k++) begin
      if (order[k] == 0) begin
        left0--;
        serve($sformatf("tie op%0d p0", k), 0, 4'b0110, 32'd9, 32'd0, 1'b1, left0 == 0);
      end else begin
        left1--;
        serve($sformatf("tie op%0d p1", k), 1, 4'b0011, 32'd0, 32'd16, 1'b0, left1 == 0);
      end
    end

    // Single-port vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].port, vecs[i].ctrl, vecs[i].in1, vecs[i].in2, vecs[i].shamt);
      serve($sformatf("vec%0d", i), vecs[i].port, vecs[i].ctrl, vecs[i].in1,
            vecs[i].exp_out, vecs[i].exp_zero, 1'b1);
    end

    // Backpressure: hold RESP five cycles; port 1's request and resp_ready are ignored.
    resp_ready_0 = 1'b0;
    drive(0, 4'b0010, 32'd100, 32'd23, 5'd0);
    #1;
    chk("bp req_ready", {30'h0, req_ready_1, req_ready_0}, 32'h1);
    tick();
    req_valid_0 = 1'b0;
    drive(1, 4'b0010, 32'd1, 32'd1, 5'd0);
    tick();
    held = resp_out;
    chk("bp first resp_out", held, 32'd123);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp stall%0d resp_valid", i), {30'h0, resp_valid_1, resp_valid_0}, 32'h1);
      chk($sformatf("bp stall%0d resp_out", i), resp_out, 32'd123);
      chk($sformatf("bp stall%0d req_ready", i), {30'h0, req_ready_1, req_ready_0}, 32'h0);
      tick();
    end
    req_valid_1 = 1'b0;
    resp_ready_0 = 1'b1;
    #1;
    chk("bp release resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h1);
    tick();
    chk("bp done resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);

    // Reset during EXEC of a port-0 op: result discarded, tie goes to port 0 again.
    drive(0, 4'b0010, 32'd1, 32'd1, 5'd0);
    #1;
    chk("rst op req_ready", {30'h0, req_ready_1, req_ready_0}, 32'h1);
    tick();
    req_valid_0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst mid alu_in1", alu_in1, 32'h0);
    chk("rst mid resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    tick();
    tick();
    chk("rst held resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    chk("rst held resp_out", resp_out, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst after resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);
    drive(0, 4'b0010, 32'd2, 32'd3, 5'd0);
    drive(1, 4'b0010, 32'd4, 32'd4, 5'd0);
    serve("post-rst p0", 0, 4'b0010, 32'd2, 32'd5, 1'b0, 1'b1);
    serve("post-rst p1", 1, 4'b0010, 32'd4, 32'd8, 1'b0, 1'b1);

    // Both ports always valid for ten operations, resp_ready tied high.
    drive(0, 4'b0010, 32'd1, 32'd2, 5'd0);
    drive(1, 4'b0010, 32'd10, 32'd20, 5'd0);
    for (int k = 0; k < 10; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      serve($sformatf("cont op%0d", k), 0, 4'b0010, 32'd1, 32'd3, 1'b0, 1'b0);
`else
      if (k % 2 == 0)
        serve($sformatf("cont op%0d", k), 0, 4'b0010, 32'd1, 32'd3, 1'b0, 1'b0);
      else
        serve($sformatf("cont op%0d", k), 1, 4'b0010, 32'd10, 32'd30, 1'b0, 1'b0);
`endif
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    tick();
    chk("final idle resp_valid", {30'h0, resp_valid_1, resp_valid_0}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. a main-pipeline port and a future multi-cycle or coprocessor port.
- Accepts one operation at a time via valid/ready handshake, drives the ALU from registered operands, captures out/zero, and returns a registered response to the granted requester.
- Sits between the requesters and the ALU instance; owns the ALU's in1/in2/shamt/ctrl inputs.

Parameters:
DATA_W, 32, operand/result width (must match ALU)
SHAMT_W, 5, shift-amount width
CTRL_W, 4, ALU opcode width (AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0110, SLT=0111, NOR=1100)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_0 / req_valid_1  input  1  request valid, port 0 / 1
req_ready_0 / req_ready_1  output  1  request accepted this cycle when valid&ready
req_ctrl_0 / req_ctrl_1  input  CTRL_W  ALU opcode
req_in1_0 / req_in1_1  input  DATA_W  operand 1
req_in2_0 / req_in2_1  input  DATA_W  operand 2
req_shamt_0 / req_shamt_1  input  SHAMT_W  shift amount
resp_valid_0 / resp_valid_1  output  1  result valid for port 0 / 1
resp_ready_0 / resp_ready_1  input  1  requester consumes result
resp_out  output  DATA_W  registered ALU result (shared by both ports)
resp_zero  output  1  registered ALU zero flag
alu_in1, alu_in2  output  DATA_W  ALU operands
alu_shamt  output  SHAMT_W  ALU shift amount
alu_ctrl  output  CTRL_W  ALU opcode
alu_out  input  DATA_W  ALU result (combinational)
alu_zero  input  1  ALU zero flag (combinational)

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- On reset:
  - state=IDLE.
  - req_ready_*=0 until IDLE arbitration is evaluated (combinational thereafter).
  - resp_valid_*=0, resp_out=0, resp_zero=0.
  - alu_in1/alu_in2/alu_shamt/alu_ctrl=0.
  - grant_id=0, last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational. Only one valid → that port granted. Both valid → port != last_grant granted (round-robin).
  - req_ready_g=1 for the granted port only; the other ready=0. No valid → both ready=0.
  - Only IDLE asserts ready.
  - On accept: latch ctrl/in1/in2/shamt into operand registers (which directly drive alu_*), set grant_id, set last_grant=grant_id, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU is driven from the operand registers.
  - On the clock edge, capture alu_out→resp_out and alu_zero→resp_zero; go to RESP.
- RESP:
  - resp_valid_<grant_id>=1; the other resp_valid=0. resp_out/resp_zero held stable.
  - On resp_ready_<grant_id>=1: resp_valid drops next cycle, go to IDLE.
  - resp_ready of the non-granted port is ignored.
- Latency:
  - Accept edge N → result captured edge N+1 → resp_valid high during cycle after N+1.
  - Minimum 3 cycles per operation with immediate resp_ready; no pipelining, one operation outstanding.
- Operand/opcode pass-through:
  - Operand registers keep their last values after an op; alu_* change only on accept.
  - Undefined ctrl codes pass through unchanged; the ALU returns 0, so resp_out=0, resp_zero=1.
- Requester rule: requester holds valid and payload stable until ready. If valid drops before grant, nothing is accepted.
- Simultaneous events:
  - New request arriving during EXEC/RESP waits (ready=0).
  - Port that just completed and re-requests loses to a waiting other port.
- Reset mid-operation: async return to IDLE; the in-flight result is discarded, no resp_valid is issued, and last_grant=1.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both valid; last_grant is not updated and not used.
- Undefined: round-robin as above.

Test Plan:
- Port 0 only, ctrl=0010, in1=5, in2=7, resp_ready_0=1 → req_ready_0 in accept cycle; alu_ctrl=0010 next cycle; resp_valid_0 two cycles after accept with resp_out=12, resp_zero=0; resp_valid_1 stays 0.
- Both valid simultaneously after reset:
  - Port 0 SUB 9-9, port 1 SLL in2=1 shamt=4.
  - Required: port 0 first (resp_out=0, resp_zero=1), then port 1 (resp_out=16).
  - With ALU_ARB_FIXED_PRIO_EN and port 0 re-requesting, port 0 is served twice before port 1.
- Backpressure: resp_ready_0=0 for 5 cycles in RESP → resp_valid_0 and resp_out held constant; both req_ready=0; completes one cycle after resp_ready_0=1.
- SLT ctrl=0111, in1=3, in2=8 → resp_out=1. Undefined ctrl=1111 → resp_out=0, resp_zero=1.
- Assert rst_n=0 during EXEC → resp_valid_* stay 0, state IDLE. Subsequent simultaneous requests grant port 0 first.
- Continuous valid on both ports for 10 operations, round-robin build → grants alternate 0,1,0,1…, each op takes exactly 3 cycles with resp_ready tied high.
